// File: rtl/bf_writeback_pkg.sv
// bf_writeback_pkg: shared defaults and FSM state type for the butterfly write-back slice
package bf_writeback_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = 8;
  localparam int BF_LATENCY = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int Q = 3329;
  typedef enum logic {UPPER, LOWER} wb_state_e;
endpackage

// File: rtl/bf_writeback_if.sv
// bf_writeback_if: issue side and write-back side of the butterfly write-back stage
//   master: upstream/sink side (drives issue, results and out_ready)
//   slave : bf_writeback (drives issue_ready, write beats and overflow_err)
interface bf_writeback_if
  import bf_writeback_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH
);
  logic                  in_valid;
  logic [addr_width-1:0] in_addr_u;
  logic [addr_width-1:0] in_addr_v;
  logic [data_width-1:0] bf_upper;
  logic [data_width-1:0] bf_lower;
  logic                  issue_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [addr_width-1:0] out_addr;
  logic [data_width-1:0] out_data;
  logic                  overflow_err;
  modport master (
    output in_valid, in_addr_u, in_addr_v, bf_upper, bf_lower, out_ready,
    input  issue_ready, out_valid, out_addr, out_data, overflow_err
  );
  modport slave (
    input  in_valid, in_addr_u, in_addr_v, bf_upper, bf_lower, out_ready,
    output issue_ready, out_valid, out_addr, out_data, overflow_err
  );
endinterface

// File: rtl/wb_pair_fifo.sv
// wb_pair_fifo: synchronous FIFO of packed {upper, addr_u, lower, addr_v} result pairs
//   clk/rst (async active-low), push/din write, pop read, dout = head entry, count = occupancy
module wb_pair_fifo #(
  parameter int width = 40,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         din,
  input  logic                     pop,
  output logic [width-1:0]         dout,
  output logic [$clog2(depth):0]   count
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_q, rd_q;
  logic [aw:0]      cnt_q;
  assign dout  = mem[rd_q];
  assign count = cnt_q;
  // power-of-two depth: pointers wrap by natural overflow, the extra count bit separates full from empty
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + aw'(push);
      rd_q  <= rd_q + aw'(pop);
      cnt_q <= cnt_q + (aw+1)'(push) - (aw+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= din;
endmodule

// File: rtl/bf_writeback.sv
// bf_writeback: aligns butterfly results with their issue addresses and writes them back as two beats
//   clk, rst (async active-low); bus (slave): issue handshake, bf results, write-back handshake, overflow_err
module bf_writeback
  import bf_writeback_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int bf_latency = BF_LATENCY,
  parameter int fifo_depth = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  bf_writeback_if.slave bus
);
  localparam int cw = $clog2(fifo_depth) + 1;
  localparam int pw = 2 * (data_width + addr_width);
  logic                  accept, cap, pop, ov_q;
  logic [bf_latency-1:0] v_q;
  logic [addr_width-1:0] au_q [bf_latency];
  logic [addr_width-1:0] av_q [bf_latency];
  logic [cw-1:0]         infl_q, infl_d, cnt;
  logic [pw-1:0]         head;
  wb_state_e             state_q, state_d;
  // in-flight plus buffered pairs can never exceed the FIFO, so a capture always finds room
  assign bus.issue_ready  = rst && (({1'b0, infl_q} + {1'b0, cnt}) < (cw+1)'(fifo_depth));
  assign accept           = bus.in_valid && bus.issue_ready;
  assign cap              = v_q[bf_latency-1];
  assign infl_d           = infl_q + cw'(accept) - cw'(cap);
  assign bus.overflow_err = ov_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_q     <= '0;
      infl_q  <= '0;
      ov_q    <= 1'b0;
      state_q <= UPPER;
    end else begin
      v_q     <= (v_q << 1) | bf_latency'(accept);
      infl_q  <= infl_d;
      ov_q    <= ov_q | (bus.in_valid && !bus.issue_ready);
      state_q <= state_d;
    end
  // address lanes only matter where the matching valid bit is set, so they carry no reset
  always_ff @(posedge clk) begin
    au_q[0] <= bus.in_addr_u;
    av_q[0] <= bus.in_addr_v;
    for (int i = 1; i < bf_latency; i++) begin
      au_q[i] <= au_q[i-1];
      av_q[i] <= av_q[i-1];
    end
  end
  wb_pair_fifo #(.width(pw), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   ({bus.bf_upper, au_q[bf_latency-1], bus.bf_lower, av_q[bf_latency-1]}),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );
  // LOWER is only entered with a non-empty FIFO and the head is not popped until its lower beat is taken
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_addr  = '0;
    bus.out_data  = '0;
    if (state_q == LOWER) begin
      bus.out_valid = 1'b1;
      bus.out_addr  = head[addr_width-1:0];
      bus.out_data  = head[addr_width+data_width-1 -: data_width];
      pop           = bus.out_ready;
      state_d       = bus.out_ready ? UPPER : LOWER;
    end else if (cnt != '0) begin
      bus.out_valid = 1'b1;
      bus.out_addr  = head[pw-data_width-1 -: addr_width];
      bus.out_data  = head[pw-1 -: data_width];
      state_d       = bus.out_ready ? LOWER : UPPER;
    end
  end
endmodule

// File: tb/tb_bf_writeback.sv
// tb_bf_writeback: randomized scoreboard bench for bf_writeback with an issue/result reference model
module tb_bf_writeback;
  import bf_writeback_pkg::*;
  localparam int L = BF_LATENCY;
  localparam int D = FIFO_DEPTH;
  typedef struct {
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    bit                    last;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bf_writeback_if #(.data_width(DATA_WIDTH), .addr_width(ADDR_WIDTH)) bus ();
  bf_writeback #(
    .data_width(DATA_WIDTH), .addr_width(ADDR_WIDTH), .bf_latency(L), .fifo_depth(D)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, acc = 0, popped = 0, c0 = 0;
  bit ov_exp = 1'b0, stalled = 1'b0, saw_block = 1'b0;
  logic [ADDR_WIDTH-1:0] held_a;
  logic [DATA_WIDTH-1:0] held_d;
  beat_t e;
  beat_t exp_q [$];
  logic [2*DATA_WIDTH-1:0] sched [int];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // one clock cycle: check registered outputs, present scheduled results, drive an issue
  task automatic tick(input bit v, input bit rdy, input bit polite,
                      input logic [ADDR_WIDTH-1:0] au, input logic [ADDR_WIDTH-1:0] av,
                      input logic [DATA_WIDTH-1:0] up, input logic [DATA_WIDTH-1:0] lo);
    @(posedge clk);
    #1;
    cyc++;
    chk("issue_ready", 32'(bus.issue_ready), 32'(rst && ((acc - popped) < D)));
    chk("overflow_err", 32'(bus.overflow_err), 32'(ov_exp));
    {bus.bf_upper, bus.bf_lower} = sched.exists(cyc) ? sched[cyc] : (2*DATA_WIDTH)'($urandom);
    if (polite) v = v && bus.issue_ready;
    bus.in_valid  = v;
    bus.in_addr_u = au;
    bus.in_addr_v = av;
    bus.out_ready = rdy;
    if (v && bus.issue_ready) begin
      exp_q.push_back('{au, up, 1'b0});
      exp_q.push_back('{av, lo, 1'b1});
      sched[cyc+L] = {up, lo};
      acc++;
    end else if (v) ov_exp = 1'b1;
  endtask
  task automatic rtick(input bit v, input bit rdy, input bit polite);
    tick(v, rdy, polite, ADDR_WIDTH'($urandom), ADDR_WIDTH'($urandom),
         DATA_WIDTH'($urandom), DATA_WIDTH'($urandom));
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      rtick(0, 1, 0);
      n++;
    end
    rtick(0, 1, 0);
    chk("drain_empty", 32'(exp_q.size()), 0);
    chk("drain_pairs", 32'(popped), 32'(acc));
  endtask
  // monitor: every accepted beat must be the oldest expected one; stalled beats must not change
  always @(negedge clk) begin
    if (!rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_addr", 32'(bus.out_addr), 32'(held_a));
        chk("hold_data", 32'(bus.out_data), 32'(held_d));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h data %0h, no beat expected (cycle %0d)",
                   bus.out_addr, bus.out_data, cyc);
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          chk("beat_addr", 32'(bus.out_addr), 32'(e.a));
          chk("beat_data", 32'(bus.out_data), 32'(e.d));
          if (e.last) popped++;
        end
        stalled = !bus.out_ready;
        held_a  = bus.out_addr;
        held_d  = bus.out_data;
      end else stalled = 1'b0;
    end
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_addr_u = '0;
    bus.in_addr_v = '0;
    bus.bf_upper  = '0;
    bus.bf_lower  = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_addr", 32'(bus.out_addr), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 0);
    chk("rst_overflow", 32'(bus.overflow_err), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("release_ready", 32'(bus.issue_ready), 1);
    // single pair: beats exactly bf_latency+1 and +2 cycles after issue
    tick(1, 1, 0, 8'h10, 8'h90, 12'h123, 12'hABC);
    c0 = cyc;
    while (cyc < c0 + L) rtick(0, 1, 0);
    chk("lat_idle", 32'(bus.out_valid), 0);
    rtick(0, 1, 0);
    chk("lat_u_valid", 32'(bus.out_valid), 1);
    chk("lat_u_addr", 32'(bus.out_addr), 32'h10);
    chk("lat_u_data", 32'(bus.out_data), 32'h123);
    rtick(0, 1, 0);
    chk("lat_v_addr", 32'(bus.out_addr), 32'h90);
    chk("lat_v_data", 32'(bus.out_data), 32'hABC);
    rtick(0, 1, 0);
    chk("lat_done", 32'(bus.out_valid), 0);
    // back-to-back issues must be throttled at D outstanding pairs
    repeat (40) begin
      rtick(1, 1, 1);
      if (!bus.issue_ready) saw_block = 1'b1;
    end
    chk("throttled", 32'(saw_block), 1);
    drain();
    // sink stalled: FIFO fills, head held, then impolite issues are dropped
    repeat (8) rtick(1, 0, 1);
    repeat (20) rtick(0, 0, 0);
    chk("full_ready", 32'(bus.issue_ready), 0);
    chk("full_valid", 32'(bus.out_valid), 1);
    repeat (3) rtick(1, 0, 0);
    rtick(0, 0, 0);
    chk("overflow_set", 32'(bus.overflow_err), 1);
    drain();
    chk("overflow_sticky", 32'(bus.overflow_err), 1);
    // out_ready toggling every cycle, including while the lower beat is pending
    for (int i = 0; i < 60; i++) rtick(i < 12, i % 2 == 1, 1);
    drain();
    repeat (300) rtick(1'($urandom), 1'($urandom), 1);
    drain();
    // reset with buffered and in-flight pairs
    repeat (2) rtick(1, 0, 1);
    repeat (9) rtick(0, 0, 0);
    repeat (3) rtick(1, 0, 1);
    rtick(0, 0, 0);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_addr", 32'(bus.out_addr), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    chk("mid_rst_ready", 32'(bus.issue_ready), 0);
    chk("mid_rst_overflow", 32'(bus.overflow_err), 0);
    exp_q.delete();
    sched.delete();
    acc    = 0;
    popped = 0;
    ov_exp = 1'b0;
    repeat (2) rtick(0, 1, 0);
    rst = 1'b1;
    #1 chk("rerelease_ready", 32'(bus.issue_ready), 1);
    repeat (20) rtick(0, 1, 0);
    repeat (30) rtick(1'($urandom), 1, 1);
    drain();
    chk("final_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
